// File: rtl/serial_cmp_pkg.sv
// Shared types and helpers for the serial magnitude comparator.
package serial_cmp_pkg;

  localparam int CMP_W_DEFAULT = 4;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_SHIFT = 2'd1;
  localparam state_t ST_DONE  = 2'd2;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/serial_mag_comp_step.sv
// One MSB-first compare step: folds the current bit pair into the decided/gt flags.
module cmp_bit_step (
  input  logic a_s,
  input  logic b_s,
  input  logic decided,
  input  logic gt,
  output logic decided_nxt,
  output logic gt_nxt,
  output logic diff
);

  assign diff        = a_s ^ b_s;
  assign decided_nxt = decided | diff;
  // The first differing bit settles the answer; later bits never override it.
  assign gt_nxt      = decided ? gt : (a_s & ~b_s);

endmodule

// File: rtl/serial_mag_comp.sv
// Bit-serial unsigned magnitude comparator, MSB first, one bit per clock.
// Optional SERIAL_CMP_EARLY_EXIT_EN: leave SHIFT as soon as the operands differ.
//
//  state | meaning
//  IDLE  | waiting for start; last result held on agtb/aeqb/altb
//  SHIFT | examining one bit pair per edge, counter counts down to 0
//  DONE  | one-cycle done strobe, result valid
module serial_mag_comp
  import serial_cmp_pkg::*;
#(
  parameter int W = CMP_W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [W-1:0] a_in,
  input  logic [W-1:0] b_in,
  output logic         busy,
  output logic         done,
  output logic         agtb,
  output logic         aeqb,
  output logic         altb
);

  localparam int CW = clog2(W);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  state_t         state;
  logic [W-1:0]   a_sh;
  logic [W-1:0]   b_sh;
  logic [CW-1:0]  cnt;
  logic           decided;
  logic           gt;
  logic           decided_nxt;
  logic           gt_nxt;
  logic           diff;
  logic           last;

  cmp_bit_step u_step (
    .a_s         (a_sh[W-1]),
    .b_s         (b_sh[W-1]),
    .decided     (decided),
    .gt          (gt),
    .decided_nxt (decided_nxt),
    .gt_nxt      (gt_nxt),
    .diff        (diff)
  );

  assign last = (cnt == '0) || (EARLY && !decided && diff);
  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      a_sh    <= '0;
      b_sh    <= '0;
      cnt     <= '0;
      decided <= 1'b0;
      gt      <= 1'b0;
      done    <= 1'b0;
      agtb    <= 1'b0;
      aeqb    <= 1'b0;
      altb    <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state   <= ST_SHIFT;
            a_sh    <= a_in;
            b_sh    <= b_in;
            cnt     <= CW'(W - 1);
            decided <= 1'b0;
            gt      <= 1'b0;
            agtb    <= 1'b0;
            aeqb    <= 1'b0;
            altb    <= 1'b0;
          end
        end
        ST_SHIFT: begin
          a_sh    <= a_sh << 1;
          b_sh    <= b_sh << 1;
          decided <= decided_nxt;
          gt      <= gt_nxt;
          if (last) begin
            state <= ST_DONE;
            done  <= 1'b1;
            agtb  <= decided_nxt & gt_nxt;
            altb  <= decided_nxt & ~gt_nxt;
            aeqb  <= ~decided_nxt;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_mag_comp.sv
// Directed and exhaustive checks of serial_mag_comp at W=4.
module tb_serial_mag_comp;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a_in;
  logic [W-1:0] b_in;
  logic         busy;
  logic         done;
  logic         agtb;
  logic         aeqb;
  logic         altb;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;

  serial_mag_comp #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a_in  (a_in),
    .b_in  (b_in),
    .busy  (busy),
    .done  (done),
    .agtb  (agtb),
    .aeqb  (aeqb),
    .altb  (altb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         gt;
    logic         eq;
    logic         lt;
    int           lat_fixed;
    int           lat_early;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int exp_lat(input logic [W-1:0] a, input logic [W-1:0] b);
    int k;
    k = W;
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    for (int i = W - 1; i >= 0; i--) begin
      if (a[i] != b[i]) begin
        k = W - i;
        break;
      end
    end
`endif
    return k + 1;
  endfunction

  // Drive one request; lat counts the accepting edge as edge 1.
  task automatic run_cmp(input logic [W-1:0] a, input logic [W-1:0] b, output int lat);
    int n;
    @(negedge clk);
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_accept", busy, 1'b1);
    n = 1;
    lat = -1;
    while (n < 20) begin
      @(posedge clk);
      #1;
      n++;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      checks++;
      $display("FAIL timeout waiting for done: got none expected done");
    end
  endtask

  int lat;
  int last_done;
  logic [W-1:0] ea, eb;

  initial begin
    vecs[0] = '{4'h9, 4'h6, 1, 0, 0, 5, 2};
    vecs[1] = '{4'hA, 4'hA, 0, 1, 0, 5, 5};
    vecs[2] = '{4'h0, 4'h1, 0, 0, 1, 5, 5};
    vecs[3] = '{4'h8, 4'h0, 1, 0, 0, 5, 2};
    vecs[4] = '{4'h3, 4'h5, 0, 0, 1, 5, 3};
    vecs[5] = '{4'hF, 4'hE, 1, 0, 0, 5, 5};
    vecs[6] = '{4'h7, 4'h8, 0, 0, 1, 5, 2};
    vecs[7] = '{4'h0, 4'h0, 0, 1, 0, 5, 5};

    rst_n = 1'b0;
    start = 1'b0;
    a_in  = '0;
    b_in  = '0;
    #1;
    chk("reset_busy", busy, 1'b0);
    chk("reset_done", done, 1'b0);
    chk("reset_results", {agtb, aeqb, altb}, 3'b000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      run_cmp(vecs[i].a, vecs[i].b, lat);
      chk("vec_result", {agtb, aeqb, altb}, {vecs[i].gt, vecs[i].eq, vecs[i].lt});
`ifdef SERIAL_CMP_EARLY_EXIT_EN
      chk("vec_latency", lat, vecs[i].lat_early);
`else
      chk("vec_latency", lat, vecs[i].lat_fixed);
`endif
      @(posedge clk);
      #1;
      chk("done_one_cycle", done, 1'b0);
      chk("idle_after_done", busy, 1'b0);
      chk("result_held", {agtb, aeqb, altb}, {vecs[i].gt, vecs[i].eq, vecs[i].lt});
    end

    // start pulsed and operands changed while busy: ignored
    @(negedge clk);
    a_in  = 4'h9;
    b_in  = 4'h6;
    start = 1'b1;
    @(posedge clk);
    #1;
    a_in = 4'h0;
    b_in = 4'hF;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_midop", busy, 1'b1);
    lat = -1;
    for (int n = 2; n < 20; n++) begin
      if (done) begin
        lat = n;
        break;
      end
      chk("busy_until_done", busy, 1'b1);
      @(posedge clk);
      #1;
    end
    chk("nostart_latency", lat, exp_lat(4'h9, 4'h6));
    chk("nostart_result", {agtb, aeqb, altb}, 3'b100);
    @(posedge clk);
    #1;
    chk("nostart_idle", busy, 1'b0);
    @(posedge clk);
    #1;
    chk("nostart_no_requeue", busy, 1'b0);

    // reset in the middle of a compare
    @(negedge clk);
    a_in  = 4'h1;
    b_in  = 4'h2;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_busy", busy, 1'b0);
    chk("abort_outputs", {done, agtb, aeqb, altb}, 4'b0000);
    for (int n = 0; n < 6; n++) begin
      @(posedge clk);
      #1;
      chk("abort_no_done", done, 1'b0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_cmp(4'h2, 4'h4, lat);
    chk("post_reset_result", {agtb, aeqb, altb}, 3'b001);
    chk("post_reset_latency", lat, exp_lat(4'h2, 4'h4));
    @(posedge clk);
    #1;

    // all pairs back-to-back with start held high
    @(negedge clk);
    a_in  = 4'h0;
    b_in  = 4'h0;
    start = 1'b1;
    last_done = 0;
    for (int i = 0; i < 256; i++) begin
      int n;
      ea = W'(i >> 4);
      eb = W'(i & 15);
      n = 0;
      while (!done && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      if (!done) begin
        errors++;
        checks++;
        $display("FAIL exhaustive timeout: pair %0d got no done", i);
        break;
      end
      chk("exh_result", {agtb, aeqb, altb}, {ea > eb, ea == eb, ea < eb});
      chk("exh_onehot", $countones({agtb, aeqb, altb}), 1);
      if (i > 0) chk("exh_spacing", cyc - last_done, exp_lat(ea, eb) + 1);
      last_done = cyc;
      if (i < 255) begin
        a_in = W'((i + 1) >> 4);
        b_in = W'((i + 1) & 15);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    start = 1'b0;
    repeat (3) @(posedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
